// File: rtl/bpug_issue_ctrl.sv
// Issue controller for a bit-processor group: per job it clears the group, loads weight banks and 16 image bytes, then issues compute/shift instructions; items reach the bpug outputs 2 cycles after generation, no backpressure.
// Optional busy-cycle counter on perf_cycles when BPUG_ISSUE_PERF_EN is defined.
module bpug_issue_ctrl #(
    parameter int ADDR_W = 12,
    parameter int N_CALC = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_img_base,
    input  logic [3:0]        cfg_n_wgt,
    input  logic [3:0]        cfg_n_up,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              bpug_enable,
    output logic              bpug_rst,
    output logic              bpug_sel,
    output logic [2:0]        bpug_wgt_sel,
    output logic [7:0]        bpug_data,
    output logic [9:0]        bpug_instr,
`ifdef BPUG_ISSUE_PERF_EN
    output logic [15:0]       perf_cycles,
`endif
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD_W, LOAD_I, CALC, SHIFT, DRAIN, DONE
    } state_t;

    localparam logic [5:0] CALC_N    = 6'(N_CALC);
    localparam logic [5:0] CALC_LAST = 6'(2 * N_CALC - 1);

    state_t            state_q, state_d;
    logic [5:0]        off_q, off_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        bank_q, bank_d;
    logic [3:0]        pass_q, pass_d;

    logic [ADDR_W-1:0] wgt_base_q, img_base_q;
    logic [3:0]        n_wgt_q, n_up_q;

    logic              s1_vld_d, s1_rd_d, s1_sel_d;
    logic [9:0]        s1_instr_d;
    logic [2:0]        s1_wgt_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic              s1_vld_q, s1_rd_q, s1_sel_q;
    logic [9:0]        s1_instr_q;
    logic [2:0]        s1_wgt_q;

    logic              out_vld_q, out_sel_q;
    logic [7:0]        out_data_q;
    logic [9:0]        out_instr_q;
    logic [2:0]        out_wgt_q;

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        k_d        = k_q;
        bank_d     = bank_q;
        pass_d     = pass_q;
        s1_vld_d   = 1'b0;
        s1_rd_d    = 1'b0;
        s1_sel_d   = 1'b0;
        s1_instr_d = '0;
        s1_wgt_d   = '0;
        mem_addr_d = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                off_d   = '0;
                k_d     = '0;
                bank_d  = '0;
                pass_d  = '0;
                state_d = (n_wgt_q != 4'd0) ? LOAD_W : LOAD_I;
            end
            LOAD_W: begin
                s1_vld_d   = 1'b1;
                s1_rd_d    = 1'b1;
                s1_instr_d = 10'h040;
                s1_wgt_d   = bank_q;
                mem_addr_d = wgt_base_q + ADDR_W'(off_q);
                off_d      = off_q + 6'd1;
                if (k_q == 3'd6) begin
                    k_d    = '0;
                    bank_d = bank_q + 3'd1;
                    if (bank_q == 3'(n_wgt_q - 4'd1)) begin
                        off_d   = '0;
                        state_d = LOAD_I;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            LOAD_I: begin
                s1_vld_d   = 1'b1;
                s1_rd_d    = 1'b1;
                s1_sel_d   = 1'b1;
                s1_instr_d = off_q[3] ? 10'h280 : 10'h080;
                mem_addr_d = img_base_q + ADDR_W'(off_q);
                off_d      = off_q + 6'd1;
                if (off_q == 6'd15) begin
                    off_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s1_vld_d = 1'b1;
                // First half-pass uses data_sel=0, second repeats the opcodes with data_sel=1.
                if (off_q < CALC_N) s1_instr_d = {5'b0, off_q[4:0]};
                else                s1_instr_d = {4'b0, 1'b1, 5'(off_q - CALC_N)};
                off_d = off_q + 6'd1;
                if (off_q == CALC_LAST) begin
                    off_d   = '0;
                    state_d = (pass_q < n_up_q) ? SHIFT : DRAIN;
                end
            end
            SHIFT: begin
                s1_vld_d   = 1'b1;
                s1_instr_d = 10'h100;
                pass_d     = pass_q + 4'd1;
                state_d    = CALC;
            end
            DRAIN: begin
                if (!s1_vld_q && !out_vld_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            off_q   <= '0;
            k_q     <= '0;
            bank_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            k_q     <= k_d;
            bank_q  <= bank_d;
            pass_q  <= pass_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_base_q <= '0;
            img_base_q <= '0;
            n_wgt_q    <= '0;
            n_up_q     <= '0;
        end else if (state_q == IDLE && start) begin
            wgt_base_q <= cfg_wgt_base;
            img_base_q <= cfg_img_base;
            n_wgt_q    <= (cfg_n_wgt > 4'd8) ? 4'd8 : cfg_n_wgt;
            n_up_q     <= cfg_n_up;
        end
    end

    // Stage 1 waits for the read data; stage 2 is the registered bpug output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_instr_q  <= '0;
            s1_wgt_q    <= '0;
            out_vld_q   <= 1'b0;
            out_sel_q   <= 1'b0;
            out_data_q  <= '0;
            out_instr_q <= '0;
            out_wgt_q   <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_rd_q     <= s1_rd_d;
            s1_sel_q    <= s1_sel_d;
            s1_instr_q  <= s1_instr_d;
            s1_wgt_q    <= s1_wgt_d;
            out_vld_q   <= s1_vld_q;
            out_sel_q   <= s1_sel_q;
            out_data_q  <= s1_rd_q ? mem_rdata : 8'h00;
            out_instr_q <= s1_instr_q;
            out_wgt_q   <= s1_wgt_q;
        end
    end

`ifdef BPUG_ISSUE_PERF_EN
    logic [15:0] perf_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_cycles_q <= '0;
        end else if (state_q != IDLE && perf_cycles_q != 16'hFFFF) begin
            perf_cycles_q <= perf_cycles_q + 16'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
`endif

    assign mem_rd       = s1_rd_d;
    assign mem_addr     = mem_addr_d;
    assign bpug_rst     = (state_q == CLR);
    assign bpug_enable  = out_vld_q | (state_q == CLR);
    assign bpug_sel     = out_sel_q;
    assign bpug_wgt_sel = out_wgt_q;
    assign bpug_data    = out_data_q;
    assign bpug_instr   = out_instr_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

// File: doc/bpug_issue_ctrl.md
BPUG_ISSUE_CTRL -- requirements
Module: bpug_issue_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 12, SHALL set the byte-address width of the operand memory.
REQ-003 Parameter N_CALC, default 7, range 1..32, SHALL set the number of compute opcodes issued per data_sel half-pass.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- start, in, 1: job request, sampled in IDLE only.
- cfg_wgt_base, in, ADDR_W: first weight byte address.
- cfg_img_base, in, ADDR_W: first image byte address.
- cfg_n_wgt, in, 4: weight banks to load, 0..8.
- cfg_n_up, in, 4: upward image shifts, 0..15.
- mem_addr, out, ADDR_W: read address.
- mem_rd, out, 1: read strobe; mem_rdata is valid the next cycle.
- mem_rdata, in, 8: read data.
- bpug_enable, out, 1: processor-group clock enable.
- bpug_rst, out, 1: processor-group synchronous clear.
- bpug_sel, out, 1: image-register select.
- bpug_wgt_sel, out, 3: weight bank select.
- bpug_data, out, 8: operand byte.
- bpug_instr, out, 10: instruction word. Bit fields:
  - [4:0] opcode.
  - [5] data_sel.
  - [7:6] en, where [7] is the image enable and [6] is the weight enable.
  - [8] img_reg_up.
  - [9] img_reg_sel.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle job-complete pulse.

Function
REQ-005 FSM states SHALL be IDLE, CLR, LOAD_W, LOAD_I, CALC, SHIFT, DRAIN, DONE.
- IDLE->CLR on start, with cfg_* captured that cycle.
- start outside IDLE SHALL be ignored.
REQ-006 CLR SHALL last 1 cycle and drive bpug_rst=1 and bpug_enable=1 directly, bypassing the pipeline.
REQ-007 LOAD_W SHALL read banks b=0..cfg_n_wgt-1, 7 bytes each, at cfg_wgt_base+7*b+k (k=0..6).
- Each byte issues with instr=0x040 and wgt_sel=b.
- cfg_n_wgt=0 SHALL skip LOAD_W.
- Values above 8 SHALL be clamped to 8.
REQ-008 LOAD_I SHALL read 16 bytes at cfg_img_base+0..15, all with bpug_sel=1.
- Bytes 0..7 issue with instr=0x080.
- Bytes 8..15 issue with instr=0x280.
REQ-009 CALC SHALL issue, with no memory read and en=00:
- opcodes 0..N_CALC-1 with data_sel=0;
- then opcodes 0..N_CALC-1 with data_sel=1;
- bpug_data=0 throughout.
REQ-010 After CALC:
- If the pass count is below cfg_n_up, the FSM SHALL enter SHIFT, issue one instr=0x100 (en=00), increment the pass count, and return to CALC.
- Otherwise the FSM SHALL enter DRAIN.
REQ-011 Issue pipeline: an item generated in cycle t (with its mem_rd/mem_addr) SHALL appear on bpug_data/bpug_instr/bpug_wgt_sel/bpug_sel in cycle t+2, with bpug_enable=1 only in cycles carrying an item.
REQ-012 Exactly one item SHALL be generated per cycle in LOAD_W, LOAD_I, CALC and SHIFT. There are no bubbles between phases.
REQ-013 DRAIN SHALL wait until the pipeline is empty. DONE SHALL then assert done for 1 cycle and return to IDLE.
REQ-014 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive.
REQ-015 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-016 When no item is present, bpug outputs SHALL be 0, apart from bpug_rst/bpug_enable during CLR.

Reset
REQ-017 rst_n low SHALL asynchronously force:
- the FSM to IDLE;
- the pipeline empty;
- the counters to 0;
- every output to 0.
REQ-018 Reset mid-job SHALL abandon the job with no done pulse. The first start after release SHALL run a full job.

Configuration
REQ-019 With BPUG_ISSUE_PERF_EN defined:
- output perf_cycles[15:0] SHALL count busy cycles of the last job, saturating at 0xFFFF;
- the count clears on start acceptance and holds after done.
Without the macro, the port and counter SHALL be absent.

Verification
REQ-020 n_wgt=2, n_up=0, N_CALC=7, wgt_base=0x010 -> the outputs SHALL show, in order:
- 14 items with instr 0x040, data from addresses 0x010..0x01D, wgt_sel 0x7 then 1x7;
- 8 items 0x080 and 8 items 0x280;
- 0x000..0x006, then 0x020..0x026;
- done once.
REQ-021 n_wgt=0, n_up=2 -> sequence LOAD_I, CALC, 0x100, CALC, 0x100, CALC; no item with instr[6]=1.
REQ-022 start pulsed during LOAD_I and on the done cycle -> ignored; exactly one job.
REQ-023 rst_n low during CALC -> all outputs 0 immediately; no done; a following start gives a clean job beginning with bpug_rst=1.
REQ-024 img_base=0xFF8 (ADDR_W=12) -> addresses 0xFF8..0xFFF then 0x000..0x007.
REQ-025 BPUG_ISSUE_PERF_EN defined, the REQ-020 job -> perf_cycles equals the measured busy cycle count and holds until the next start.
